imem_loader: RTL

Boot-time writer for the instruction memory: accepts a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and issues word-aligned writes into the instruction RAM that the CPU fetch path reads. Holds the CPU in reset until the whole image is written (and, optionally, checksum-verified). Sits between the serial receiver and the write port of the instruction memory. The fetch side is untouched.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory boot loader
// Contents: loader state enum, stream header length, bytes per memory word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Header is the 16-bit little-endian word count.
  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port and status out
// Signals: in_data/in_valid/in_ready (byte stream), wr_en/wr_addr/wr_data (memory
// write port), cpu_rst_hold/done/error (boot status).
// Modports: master = stream source and memory/status observer, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
);

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  cpu_rst_hold;
  logic                  done;
  logic                  error;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_rst_hold, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_rst_hold, done, error
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles LSB-first bytes into 32-bit words
// Ports: clk, rst (async, active-high), clear (drop partial word), byte_valid/byte_data
// (one accepted byte), word/word_valid (registered word, one-cycle pulse on every 4th
// byte), last_byte (the next accepted byte completes a word).
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [1:0]  idx;
  logic [23:0] partial;

  assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      partial    <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx     <= 2'd0;
        partial <= 24'd0;
      end else if (byte_valid) begin
        idx <= idx + 2'd1;
        if (last_byte) begin
          word       <= {byte_data, partial};
          word_valid <= 1'b1;
          partial    <= 24'd0;
        end else begin
          // Newest byte enters at the top so b0 ends up in the low lane.
          partial <= {byte_data, partial[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte stream to instruction memory writer
// Ports: clk, rst (async, active-high), bus (imem_loader_if.slave): in_data/in_valid/
// in_ready stream, wr_en/wr_addr/wr_data memory write, cpu_rst_hold/done/error status.
// Stream: N[7:0], N[15:8], then 4N payload bytes, little-endian per word.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: expects a trailing byte that makes the
// mod-256 sum of all payload bytes zero; a bad sum ends in ERROR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.slave   bus
);

  localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_WIDTH - 2);

  state_t                state;
  logic [15:0]           len_q;
  logic [15:0]           word_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  in_ready_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  error_q;
  logic [WORD_WIDTH-1:0] packed_word;
  logic                  packed_valid;
  logic                  last_byte;
  logic                  accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  assign accept = bus.in_valid & in_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept && state == LEN_HI),
    .byte_valid (accept && state == DATA),
    .byte_data  (bus.in_data),
    .word       (packed_word),
    .word_valid (packed_valid),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LEN_LO;
      len_q      <= 16'd0;
      word_cnt   <= 16'd0;
      wr_addr_q  <= '0;
      in_ready_q <= 1'b1;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else if (accept) begin
      case (state)
        LEN_LO: begin
          len_q[7:0] <= bus.in_data;
          state      <= LEN_HI;
        end
        LEN_HI: begin
          len_q[15:8] <= bus.in_data;
          if ({bus.in_data, len_q[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state      <= DONE;
            in_ready_q <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else if ({16'd0, bus.in_data, len_q[7:0]} > CAPACITY) begin
            state      <= ERROR;
            in_ready_q <= 1'b0;
            error_q    <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + bus.in_data;
`endif
          if (last_byte) begin
            // Address is published alongside the packer's word on the same edge.
            wr_addr_q <= ADDR_WIDTH'(word_cnt * BYTES_PER_WORD);
            word_cnt  <= word_cnt + 16'd1;
            if (word_cnt == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state      <= DONE;
              in_ready_q <= 1'b0;
              hold_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          in_ready_q <= 1'b0;
          if (sum_q + bus.in_data == 8'd0) begin
            state  <= DONE;
            hold_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state   <= ERROR;
            error_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.wr_en        = packed_valid;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = packed_word;
  assign bus.cpu_rst_hold = hold_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule
